// File: rtl/program_loader.sv
// Program loader: takes a stream of received bytes and writes them one at a time into
// instruction memory. It also assembles each aligned 4-byte group into an instruction word.
// Loading ends when an aligned word equals HALT_WORD (done) or when the last memory
// location has been written without one (overflow).
module program_loader #(
    parameter int unsigned MEMORY_WIDTH   = 8,
    parameter int unsigned MEMORY_DEPTH   = 256,
    parameter int unsigned NB_ADDR_DEPTH  = 8,
    parameter int unsigned NB_INSTRUCTION = 32,
    parameter logic [NB_INSTRUCTION-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_rx_done,
    input  logic [MEMORY_WIDTH-1:0]  i_rx_data,
    output logic                     o_write_enable,
    output logic [MEMORY_WIDTH-1:0]  o_write_data,
    output logic [NB_ADDR_DEPTH-1:0] o_write_addr,
    output logic                     o_mem_enable,
    output logic                     o_busy,
    output logic                     o_load_done,
    output logic                     o_overflow
);

    localparam logic [NB_ADDR_DEPTH-1:0] LastAddr = NB_ADDR_DEPTH'(MEMORY_DEPTH - 1);
    localparam logic [1:0]               LastIdx  = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StReceive,
        StWrite,
        StDone,
        StOverflow
    } state_e;

    state_e                    state_q, state_d;
    logic [NB_ADDR_DEPTH-1:0]  addr_q, addr_d;
    logic [1:0]                idx_q, idx_d;
    logic [NB_INSTRUCTION-1:0] word_q, word_d;
    logic                      pend_q, pend_d;
    logic [MEMORY_WIDTH-1:0]   pend_data_q, pend_data_d;
    logic [MEMORY_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB_ADDR_DEPTH-1:0]  waddr_q, waddr_d;
    logic                      we_q, we_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      ovf_q, ovf_d;

    // A byte held over from a WRITE cycle takes priority over the live receive port.
    logic [MEMORY_WIDTH-1:0]   rx_byte;
    assign rx_byte = pend_q ? pend_data_q : i_rx_data;

    // Next-state logic; registered outputs are decoded from the next state so they line up
    // with the state they describe.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        word_d      = word_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        wdata_d     = wdata_q;
        waddr_d     = waddr_q;

        unique case (state_q)
            StIdle, StDone, StOverflow: begin
                if (i_start) begin
                    state_d     = StReceive;
                    addr_d      = '0;
                    idx_d       = '0;
                    word_d      = '0;
                    pend_d      = 1'b0;
                    pend_data_d = '0;
                end
            end
            StReceive: begin
                if (pend_q || i_rx_done) begin
                    wdata_d = rx_byte;
                    waddr_d = addr_q;
                    word_d  = {word_q[NB_INSTRUCTION-MEMORY_WIDTH-1:0], rx_byte};
                    state_d = StWrite;
                    // Pending byte consumed; a byte arriving in the same cycle refills it.
                    if (pend_q && i_rx_done) begin
                        pend_d      = 1'b1;
                        pend_data_d = i_rx_data;
                    end else begin
                        pend_d = 1'b0;
                    end
                end
            end
            StWrite: begin
                if (i_rx_done) begin
                    pend_d      = 1'b1;
                    pend_data_d = i_rx_data;
                end
                addr_d = addr_q + 1'b1;
                idx_d  = idx_q + 2'd1;
                // Only an aligned group can terminate the load.
                if (idx_q == LastIdx && word_q == HALT_WORD) begin
                    state_d = StDone;
                end else if (addr_q == LastAddr) begin
                    state_d = StOverflow;
                end else begin
                    state_d = StReceive;
                end
            end
            default: state_d = StIdle;
        endcase

        we_d   = (state_d == StWrite);
        busy_d = (state_d == StReceive) || (state_d == StWrite);
        done_d = (state_d == StDone);
        ovf_d  = (state_d == StOverflow);
    end

    // State, datapath and output registers; reset clears everything immediately.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            wdata_q     <= '0;
            waddr_q     <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign o_write_enable = we_q;
    assign o_write_data   = wdata_q;
    assign o_write_addr   = waddr_q;
    assign o_mem_enable   = busy_q;
    assign o_busy         = busy_q;
    assign o_load_done    = done_q;
    assign o_overflow     = ovf_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a directed vector table plus hand-written
// sequences for async reset mid-write, overflow and a halt word in the final location.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] waddr;
    logic       mem_en;
    logic       busy;
    logic       done;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    program_loader dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_rx_done      (rx_done),
        .i_rx_data      (rx_data),
        .o_write_enable (we),
        .o_write_data   (wdata),
        .o_write_addr   (waddr),
        .o_mem_enable   (mem_en),
        .o_busy         (busy),
        .o_load_done    (done),
        .o_overflow     (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       rx;
        logic [7:0] data;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       busy;
        logic       done;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    // Status bundle: {write_enable, busy, mem_enable, load_done, overflow}
    function automatic logic [4:0] st(input logic w, input logic b, input logic d,
                                      input logic o);
        return {w, b, b, d, o};
    endfunction

    function automatic logic [4:0] dut_st();
        return {we, busy, mem_en, done, ovf};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic s, input logic r, input logic [7:0] d, input logic w,
                        input logic [7:0] a, input logic [7:0] wd, input logic b,
                        input logic dn, input logic o);
        vec_t v;
        v.start = s; v.rx = r; v.data = d; v.we = w; v.addr = a; v.wdata = wd;
        v.busy = b; v.done = dn; v.ovf = o;
        vecs.push_back(v);
    endtask

    // One byte: write strobe next cycle, then back in RECEIVE with nothing written.
    task automatic push_byte(input logic [7:0] d, input logic [7:0] a);
        push(1'b0, 1'b1, d, 1'b1, a, d, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    // Apply inputs for one cycle and sample 1 time unit after the rising edge.
    task automatic cyc(input logic s, input logic r, input logic [7:0] d);
        start = s; rx_done = r; rx_data = d;
        @(posedge clk);
        #1;
        start = 1'b0; rx_done = 1'b0;
    endtask

    task automatic feed(input logic [7:0] d, input logic [7:0] a, input string tag);
        cyc(1'b0, 1'b1, d);
        check($sformatf("%s write @%0d", tag, a), {dut_st(), waddr, wdata},
              {st(1'b1, 1'b1, 1'b0, 1'b0), a, d});
    endtask

    task automatic gap(input string tag);
        cyc(1'b0, 1'b0, 8'h00);
        check($sformatf("%s gap", tag), dut_st(), st(1'b0, 1'b1, 1'b0, 1'b0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {dut_st(), waddr, wdata}, '0);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 8'h77);
        check("rx in idle ignored", dut_st(), st(1'b0, 1'b0, 1'b0, 1'b0));

        // Program 20 01 00 05 + halt, with a start mid-load that must be ignored.
        push(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        push_byte(8'h20, 8'd0);
        push(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        push_byte(8'h01, 8'd1);
        push_byte(8'h00, 8'd2);
        push_byte(8'h05, 8'd3);
        push_byte(8'hFF, 8'd4);
        push_byte(8'hFF, 8'd5);
        push_byte(8'hFF, 8'd6);
        push(1'b0, 1'b1, 8'hFF, 1'b1, 8'd7, 8'hFF, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        push(1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        // Restart from DONE; unaligned FF FF FF FF must not halt.
        push(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        push_byte(8'h00, 8'd0);
        push_byte(8'hFF, 8'd1);
        push_byte(8'hFF, 8'd2);
        push_byte(8'hFF, 8'd3);
        push_byte(8'hFF, 8'd4);
        push_byte(8'h00, 8'd5);
        push_byte(8'h00, 8'd6);
        push_byte(8'h00, 8'd7);
        push_byte(8'h44, 8'd8);
        // Back-to-back bytes: second one arrives during WRITE and is held.
        push(1'b0, 1'b1, 8'h11, 1'b1, 8'd9, 8'h11, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'h00, 1'b1, 8'd10, 8'h22, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            cyc(vecs[i].start, vecs[i].rx, vecs[i].data);
            check($sformatf("vec %0d status", i), dut_st(),
                  st(vecs[i].we, vecs[i].busy, vecs[i].done, vecs[i].ovf));
            if (vecs[i].we) begin
                check($sformatf("vec %0d addr/data", i), {waddr, wdata},
                      {vecs[i].addr, vecs[i].wdata});
            end
        end

        // Async reset from mid-load, then a fresh load interrupted during the addr 3 write.
        rst = 1'b1;
        #1;
        check("reset mid-load", {dut_st(), waddr, wdata}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b1, 8'h66);
        check("no write after reset", dut_st(), st(1'b0, 1'b0, 1'b0, 1'b0));
        cyc(1'b1, 1'b0, 8'h00);
        check("start after reset", dut_st(), st(1'b0, 1'b1, 1'b0, 1'b0));
        feed(8'h10, 8'd0, "rst"); gap("rst");
        feed(8'h11, 8'd1, "rst"); gap("rst");
        feed(8'h12, 8'd2, "rst"); gap("rst");
        feed(8'h13, 8'd3, "rst");
        rst = 1'b1;
        #1;
        check("reset during write", {dut_st(), waddr, wdata}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b1, 8'h99);
        check("no write before start", dut_st(), st(1'b0, 1'b0, 1'b0, 1'b0));
        cyc(1'b1, 1'b0, 8'h00);
        check("restart", dut_st(), st(1'b0, 1'b1, 1'b0, 1'b0));

        // 256 zero bytes fill memory without a halt.
        for (int a = 0; a < 256; a++) begin
            feed(8'h00, 8'(a), "ovf");
            if (a < 255) gap("ovf");
        end
        cyc(1'b0, 1'b0, 8'h00);
        check("overflow flag", dut_st(), st(1'b0, 1'b0, 1'b0, 1'b1));
        cyc(1'b0, 1'b1, 8'h5A);
        check("rx in overflow ignored", dut_st(), st(1'b0, 1'b0, 1'b0, 1'b1));

        // Restart from OVERFLOW; a halt word in the final four locations ends in DONE.
        cyc(1'b1, 1'b0, 8'h00);
        check("restart from overflow", dut_st(), st(1'b0, 1'b1, 1'b0, 1'b0));
        for (int a = 0; a < 256; a++) begin
            feed((a >= 252) ? 8'hFF : 8'h00, 8'(a), "last");
            if (a < 255) gap("last");
        end
        cyc(1'b0, 1'b0, 8'h00);
        check("halt on final word", dut_st(), st(1'b0, 1'b0, 1'b1, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEMORY_WIDTH, default 8, SHALL set the byte width written to instruction memory.
REQ-002 Parameter MEMORY_DEPTH, default 256, SHALL set the number of byte locations loadable.
REQ-003 Parameter NB_ADDR_DEPTH, default 8, SHALL set the write address width.
REQ-004 Parameter NB_INSTRUCTION, default 32, SHALL set the instruction word width (4 bytes).
REQ-005 Parameter HALT_WORD, default 32'hFFFFFFFF, SHALL set the end-of-program instruction.
REQ-006 i_clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 i_reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-008 i_start  in  1  SHALL request a new load; single-cycle pulse.
REQ-009 i_rx_done  in  1  SHALL flag one valid received byte per asserted cycle.
REQ-010 i_rx_data  in  MEMORY_WIDTH  SHALL carry the received byte, valid with i_rx_done.
REQ-011 o_write_enable  out  1  SHALL drive the memory byte write strobe.
REQ-012 o_write_data  out  MEMORY_WIDTH  SHALL carry the byte to write.
REQ-013 o_write_addr  out  NB_ADDR_DEPTH  SHALL carry the byte write address.
REQ-014 o_mem_enable  out  1  SHALL enable instruction memory during loading.
REQ-015 o_busy  out  1  SHALL be high while a load is in progress.
REQ-016 o_load_done  out  1  SHALL be high after HALT_WORD has been written.
REQ-017 o_overflow  out  1  SHALL be high when memory filled without HALT_WORD.

Function
REQ-018 States SHALL be IDLE, RECEIVE, WRITE, DONE, OVERFLOW; all outputs registered.
REQ-019 IDLE: i_start -> RECEIVE; byte address, byte index (0..3), word shift register and pending flag cleared to 0.
REQ-020 RECEIVE: i_rx_done (or pending flag set) -> latch byte into o_write_data, current address into o_write_addr, go WRITE; otherwise stay.
REQ-021 WRITE SHALL last exactly one cycle with o_write_enable=1; every other state drives o_write_enable=0.
REQ-022 Latency: i_rx_done in RECEIVE at cycle N -> o_write_enable=1 at cycle N+1.
REQ-023 Byte order big-endian: first byte of each word at lowest address, shifted into word register MSB-first.
REQ-024 Leaving WRITE, address SHALL increment by 1 and byte index by 1 modulo 4.
REQ-025 HALT check only when written byte had index 3: assembled word == HALT_WORD -> DONE.
REQ-026 HALT_WORD pattern spanning a non-aligned group SHALL NOT terminate the load.
REQ-027 If no HALT and written address == MEMORY_DEPTH-1 -> OVERFLOW (no wrap to 0); else -> RECEIVE.
REQ-028 HALT on final word (address MEMORY_DEPTH-1) SHALL give DONE, not OVERFLOW.
REQ-029 i_rx_done during WRITE SHALL latch i_rx_data into a one-entry pending register and set pending flag; consumed by next RECEIVE cycle, flag cleared.
REQ-030 i_rx_done in IDLE, DONE, OVERFLOW SHALL be ignored.
REQ-031 o_busy=1 and o_mem_enable=1 in RECEIVE and WRITE only.
REQ-032 o_load_done=1 only in DONE; o_overflow=1 only in OVERFLOW; each holds until next i_start.
REQ-033 i_start in DONE or OVERFLOW SHALL behave as in IDLE (restart at address 0, flags cleared next cycle).
REQ-034 i_start in RECEIVE or WRITE SHALL be ignored.

Reset
REQ-035 i_reset asserted at any time, including mid-WRITE, SHALL immediately force IDLE and all outputs, address, index, word and pending registers to 0.
REQ-036 After i_reset deasserts, no write SHALL occur until i_start.

Verification
REQ-037 i_start; bytes 0x20,0x01,0x00,0x05 then 0xFF x4 -> writes addr 0..7 with those bytes, o_load_done=1 cycle after addr 7 write, o_busy=0.
REQ-038 i_rx_done=1 data 0xAB at cycle N in RECEIVE -> o_write_enable=1, o_write_addr=current, o_write_data=0xAB at N+1 only.
REQ-039 bytes 0x00,0xFF,0xFF,0xFF,0xFF,0x00,0x00,0x00 -> no DONE after byte 5 (unaligned); load continues at addr 8.
REQ-040 256 bytes 0x00 -> last write addr 0xFF, then o_overflow=1, o_write_enable stays 0, further i_rx_done ignored.
REQ-041 i_rx_done on two consecutive cycles (0x11,0x22) -> writes 0x11 @addr k, 0x22 @addr k+1, none lost.
REQ-042 i_reset pulsed during WRITE at addr 3 -> o_write_enable=0 immediately, all outputs 0; i_start then writes from addr 0.
